// File: rtl/fem_sketch.sv
// Count-min flow sketch: for every accepted packet it updates N_HASH rows of packet
// and byte counters, then returns the min-of-rows estimates with the echoed features.
module fem_sketch #(
  parameter int DATA_WIDTH    = 32,
  parameter int N_FEATURES    = 28,
  parameter int N_HASH        = 4,
  parameter int SKETCH_DEPTH  = 256,
  parameter int KEY_WIDTH     = 104,
  parameter int CNT_WIDTH     = 16,
  parameter int BYTE_WIDTH    = 32,
  parameter int WINDOW_CYCLES = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             pkt_valid,
  output logic                             pkt_ready,
  input  logic [KEY_WIDTH-1:0]             flow_key,
  input  logic [15:0]                      pkt_bytes,
  input  logic [N_FEATURES*DATA_WIDTH-1:0] pkt_features,
  input  logic                             clear_req,
  output logic                             agg_valid,
  input  logic                             agg_ready,
  output logic [N_FEATURES*DATA_WIDTH-1:0] agg_features,
  output logic [CNT_WIDTH-1:0]             agg_pkt_est,
  output logic [BYTE_WIDTH-1:0]            agg_byte_est,
  output logic                             clearing
);

  localparam int IDX_W  = $clog2(SKETCH_DEPTH);
  localparam int NSLICE = (KEY_WIDTH + IDX_W - 1) / IDX_W;
  localparam int PAD_W  = NSLICE * IDX_W;
  localparam int WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_LOOKUP, S_UPDATE, S_OUTPUT} state_t;

  // Row index: fold key ^ rotl(key, 7h+1) into IDX_W bits; the top slice is zero-padded.
  function automatic logic [IDX_W-1:0] f_index(input logic [KEY_WIDTH-1:0] key,
                                               input int unsigned h);
    logic [KEY_WIDTH-1:0] k;
    logic [PAD_W-1:0]     kp;
    logic [IDX_W-1:0]     idx;
    int unsigned          rot;
    rot = (7 * h + 1) % KEY_WIDTH;
    k   = key ^ ((key << rot) | (key >> (KEY_WIDTH - rot)));
    kp  = PAD_W'(k);
    idx = '0;
    for (int unsigned s = 0; s < NSLICE; s++) idx ^= IDX_W'(kp >> (s * IDX_W));
    return idx;
  endfunction

  state_t                          r_state, w_next;
  logic [IDX_W-1:0]                r_clr_addr;
  logic [KEY_WIDTH-1:0]            r_key;
  logic [15:0]                     r_bytes;
  logic [N_FEATURES*DATA_WIDTH-1:0] r_feat;
  logic [CNT_WIDTH-1:0]            r_pkt_est;
  logic [BYTE_WIDTH-1:0]           r_byte_est;
  logic [WIN_W-1:0]                r_win_cnt;
  logic                            r_pend;
  logic                            w_accept, w_go_clear, w_wrap;

  logic [CNT_WIDTH-1:0]  r_pkt_mem  [N_HASH][SKETCH_DEPTH];
  logic [BYTE_WIDTH-1:0] r_byte_mem [N_HASH][SKETCH_DEPTH];
  logic [CNT_WIDTH-1:0]  r_pkt_rd   [N_HASH];
  logic [BYTE_WIDTH-1:0] r_byte_rd  [N_HASH];
  logic [IDX_W-1:0]      w_idx      [N_HASH];
  logic [CNT_WIDTH-1:0]  w_pkt_new  [N_HASH];
  logic [BYTE_WIDTH:0]   w_bsum     [N_HASH];
  logic [BYTE_WIDTH-1:0] w_byte_new [N_HASH];
  logic [CNT_WIDTH-1:0]  w_pkt_min;
  logic [BYTE_WIDTH-1:0] w_byte_min;

  always_comb begin
    for (int unsigned h = 0; h < N_HASH; h++) begin
      w_idx[h]      = f_index(r_key, h);
      w_pkt_new[h]  = (r_pkt_rd[h] == '1) ? r_pkt_rd[h] : r_pkt_rd[h] + CNT_WIDTH'(1);
      w_bsum[h]     = {1'b0, r_byte_rd[h]} + (BYTE_WIDTH+1)'(r_bytes);
      w_byte_new[h] = w_bsum[h][BYTE_WIDTH] ? '1 : w_bsum[h][BYTE_WIDTH-1:0];
    end
    w_pkt_min  = w_pkt_new[0];
    w_byte_min = w_byte_new[0];
    for (int unsigned h = 1; h < N_HASH; h++) begin
      if (w_pkt_new[h]  < w_pkt_min)  w_pkt_min  = w_pkt_new[h];
      if (w_byte_new[h] < w_byte_min) w_byte_min = w_byte_new[h];
    end
  end

  assign w_wrap = (WINDOW_CYCLES != 0) && (r_win_cnt == WIN_W'(WINDOW_CYCLES - 1));

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_go_clear = 1'b0;
    case (r_state)
      S_CLEAR:  if (r_clr_addr == IDX_W'(SKETCH_DEPTH - 1)) w_next = S_IDLE;
      S_IDLE: begin
        // A waiting packet wins over a pending clear; the clear follows its OUTPUT.
        if (pkt_valid) begin
          w_accept = 1'b1;
          w_next   = S_LOOKUP;
        end else if (r_pend) begin
          w_go_clear = 1'b1;
          w_next     = S_CLEAR;
        end
      end
      S_LOOKUP: w_next = S_UPDATE;
      S_UPDATE: w_next = S_OUTPUT;
      S_OUTPUT: begin
        if (agg_ready) begin
          w_go_clear = r_pend;
          w_next     = r_pend ? S_CLEAR : S_IDLE;
        end
      end
      default:  w_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
      r_key      <= '0;
      r_bytes    <= '0;
      r_feat     <= '0;
      r_pkt_est  <= '0;
      r_byte_est <= '0;
      r_win_cnt  <= '0;
      r_pend     <= 1'b0;
      for (int unsigned h = 0; h < N_HASH; h++) begin
        r_pkt_rd[h]  <= '0;
        r_byte_rd[h] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (r_state == S_CLEAR) r_clr_addr <= r_clr_addr + IDX_W'(1);
      if (w_accept) begin
        r_key   <= flow_key;
        r_bytes <= pkt_bytes;
        r_feat  <= pkt_features;
      end
      if (r_state == S_LOOKUP) begin
        for (int unsigned h = 0; h < N_HASH; h++) begin
          r_pkt_rd[h]  <= r_pkt_mem[h][w_idx[h]];
          r_byte_rd[h] <= r_byte_mem[h][w_idx[h]];
        end
      end
      if (r_state == S_UPDATE) begin
        r_pkt_est  <= w_pkt_min;
        r_byte_est <= w_byte_min;
      end
      if (WINDOW_CYCLES != 0) r_win_cnt <= w_wrap ? '0 : r_win_cnt + WIN_W'(1);
      if (r_state == S_CLEAR || w_go_clear) r_pend <= 1'b0;
      else if (w_wrap || clear_req)         r_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      for (int unsigned h = 0; h < N_HASH; h++) begin
        r_pkt_mem[h][r_clr_addr]  <= '0;
        r_byte_mem[h][r_clr_addr] <= '0;
      end
    end else if (r_state == S_UPDATE) begin
      for (int unsigned h = 0; h < N_HASH; h++) begin
        r_pkt_mem[h][w_idx[h]]  <= w_pkt_new[h];
        r_byte_mem[h][w_idx[h]] <= w_byte_new[h];
      end
    end
  end

  assign pkt_ready    = (r_state == S_IDLE);
  assign agg_valid    = (r_state == S_OUTPUT);
  assign clearing     = (r_state == S_CLEAR);
  assign agg_features = r_feat;
  assign agg_pkt_est  = r_pkt_est;
  assign agg_byte_est = r_byte_est;

endmodule

// File: tb/tb_fem_sketch.sv
// Directed bench for fem_sketch: default instance, a 4-bit-counter instance and a
// windowed instance share stimulus; sel chooses which one a step drives and observes.
module tb_fem_sketch;

  localparam int NF = 28;
  localparam int DW = 32;
  localparam int FW = NF * DW;

  logic clk, rst_n, clear_req, agg_ready;
  logic [2:0] vld, rdy, av, clr;
  logic [103:0] flow_key;
  logic [15:0]  pkt_bytes;
  logic [FW-1:0] pkt_features, feat0, feat1, feat2;
  logic [15:0] pest0, pest2;
  logic [3:0]  pest1;
  logic [31:0] best0, best1, best2;

  int sel;
  int checks, errors;
  int cyc;
  logic          m_ready, m_valid, m_clearing;
  logic [15:0]   m_pest;
  logic [31:0]   m_best;
  logic [FW-1:0] m_feat;

  fem_sketch dut (
    .clk(clk), .rst_n(rst_n), .pkt_valid(vld[0]), .pkt_ready(rdy[0]),
    .flow_key(flow_key), .pkt_bytes(pkt_bytes), .pkt_features(pkt_features),
    .clear_req(clear_req), .agg_valid(av[0]), .agg_ready(agg_ready),
    .agg_features(feat0), .agg_pkt_est(pest0), .agg_byte_est(best0), .clearing(clr[0]));

  fem_sketch #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .pkt_valid(vld[1]), .pkt_ready(rdy[1]),
    .flow_key(flow_key), .pkt_bytes(pkt_bytes), .pkt_features(pkt_features),
    .clear_req(clear_req), .agg_valid(av[1]), .agg_ready(agg_ready),
    .agg_features(feat1), .agg_pkt_est(pest1), .agg_byte_est(best1), .clearing(clr[1]));

  fem_sketch #(.WINDOW_CYCLES(1000)) dut_win (
    .clk(clk), .rst_n(rst_n), .pkt_valid(vld[2]), .pkt_ready(rdy[2]),
    .flow_key(flow_key), .pkt_bytes(pkt_bytes), .pkt_features(pkt_features),
    .clear_req(clear_req), .agg_valid(av[2]), .agg_ready(agg_ready),
    .agg_features(feat2), .agg_pkt_est(pest2), .agg_byte_est(best2), .clearing(clr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  always_comb begin
    case (sel)
      1: begin
        m_ready = rdy[1]; m_valid = av[1]; m_clearing = clr[1];
        m_pest = {12'b0, pest1}; m_best = best1; m_feat = feat1;
      end
      2: begin
        m_ready = rdy[2]; m_valid = av[2]; m_clearing = clr[2];
        m_pest = pest2; m_best = best2; m_feat = feat2;
      end
      default: begin
        m_ready = rdy[0]; m_valid = av[0]; m_clearing = clr[0];
        m_pest = pest0; m_best = best0; m_feat = feat0;
      end
    endcase
  end

  function automatic logic [FW-1:0] mkfeat(input int seed);
    logic [FW-1:0] v;
    for (int f = 0; f < NF; f++)
      v[f*DW +: DW] = (32'(seed) * 32'h0101_0101) ^ 32'(f) ^ 32'hC0DE_0000;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one packet, checks 3-cycle latency, estimates, echo, and optional backpressure.
  // clr_mode: 0 none, 1 clear_req together with pkt_valid, 2 clear_req in OUTPUT.
  task automatic send(input string tag, input logic [103:0] key, input logic [15:0] nbytes,
                      input int seed, input logic [15:0] exp_pkt, input logic [31:0] exp_byte,
                      input int hold, input int clr_mode);
    int n;
    logic [FW-1:0] f;
    f = mkfeat(seed);
    n = 0;
    while (!m_ready && n < 2000) begin @(negedge clk); n++; end
    chk({tag, ".ready"}, 64'(m_ready), 64'd1);
    flow_key = key; pkt_bytes = nbytes; pkt_features = f;
    vld[sel] = 1'b1;
    if (clr_mode == 1) clear_req = 1'b1;
    @(negedge clk);
    vld = '0; clear_req = 1'b0;
    chk({tag, ".lat1"}, 64'(m_valid), 64'd0);
    @(negedge clk);
    chk({tag, ".lat2"}, 64'(m_valid), 64'd0);
    @(negedge clk);
    chk({tag, ".lat3"}, 64'(m_valid), 64'd1);
    chk({tag, ".pkt_est"}, 64'(m_pest), 64'(exp_pkt));
    chk({tag, ".byte_est"}, 64'(m_best), 64'(exp_byte));
    chk({tag, ".feat"}, 64'(m_feat === f), 64'd1);
    if (clr_mode == 2) clear_req = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      clear_req = 1'b0;
      chk({tag, ".hold_valid"}, 64'(m_valid), 64'd1);
      chk({tag, ".hold_ready"}, 64'(m_ready), 64'd0);
      chk({tag, ".hold_pkt"}, 64'(m_pest), 64'(exp_pkt));
      chk({tag, ".hold_byte"}, 64'(m_best), 64'(exp_byte));
      chk({tag, ".hold_feat"}, 64'(m_feat === f), 64'd1);
    end
    agg_ready = 1'b1;
    @(negedge clk);
    agg_ready = 1'b0; clear_req = 1'b0;
    chk({tag, ".valid_drop"}, 64'(m_valid), 64'd0);
  endtask

  task automatic wait_sweep(input string tag, input bit pulse_mid);
    int n;
    bit saw_ready;
    n = 0; saw_ready = 1'b0;
    while (m_clearing && n < 1000) begin
      if (m_ready) saw_ready = 1'b1;
      clear_req = pulse_mid && (n == 10);
      @(negedge clk);
      n++;
    end
    clear_req = 1'b0;
    chk({tag, ".sweep_len"}, 64'(n), 64'd256);
    chk({tag, ".no_ready_in_sweep"}, 64'(saw_ready), 64'd0);
    chk({tag, ".ready_after"}, 64'(m_ready), 64'd1);
    repeat (2) @(negedge clk);
    chk({tag, ".no_resweep"}, 64'(m_clearing), 64'd0);
  endtask

  localparam logic [103:0] K1 = 104'd1;
  localparam logic [103:0] K2 = 104'd2;

  initial begin
    int acc;
    checks = 0; errors = 0; sel = 0;
    rst_n = 1'b1; vld = '0; clear_req = 1'b0; agg_ready = 1'b0;
    flow_key = '0; pkt_bytes = '0; pkt_features = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.ready", 64'(m_ready), 64'd0);
    chk("rst.valid", 64'(m_valid), 64'd0);
    chk("rst.clearing", 64'(m_clearing), 64'd1);
    chk("rst.pkt_est", 64'(m_pest), 64'd0);
    chk("rst.byte_est", 64'(m_best), 64'd0);
    chk("rst.feat", 64'(m_feat === '0), 64'd1);
    rst_n = 1'b1;
    wait_sweep("init", 1'b0);

    send("est1", K1, 16'd100, 1, 16'd1, 32'd100, 0, 0);
    send("est2", K1, 16'd200, 2, 16'd2, 32'd300, 0, 0);
    send("est3", K1, 16'd300, 3, 16'd3, 32'd600, 0, 0);

    // agg_ready held high with a continuously offered packet: one accept per 4 cycles.
    flow_key = K2; pkt_bytes = 16'd1; pkt_features = mkfeat(50);
    agg_ready = 1'b1; vld[0] = 1'b1; acc = 0;
    for (int i = 0; i < 16; i++) begin
      if (m_ready) acc++;
      if (i == 15) chk("thru.pkt_est", 64'(m_pest), 64'd4);
      @(negedge clk);
    end
    vld = '0; agg_ready = 1'b0;
    chk("thru.accepts", 64'(acc), 64'd4);
    chk("thru.idle", 64'(m_ready), 64'd1);

    send("bp", K1, 16'd50, 4, 16'd4, 32'd650, 10, 0);
    chk("bp.single", 64'(m_valid), 64'd0);

    send("clr_out", K1, 16'd5, 5, 16'd5, 32'd655, 2, 2);
    chk("clr_out.sweep_start", 64'(m_clearing), 64'd1);
    wait_sweep("clr_out", 1'b1);
    send("clr_acc", K1, 16'd7, 6, 16'd1, 32'd7, 0, 1);
    chk("clr_acc.sweep_start", 64'(m_clearing), 64'd1);
    wait_sweep("clr_acc", 1'b0);
    send("post_clr", K1, 16'd9, 7, 16'd1, 32'd9, 0, 0);

    sel = 1;
    for (int i = 1; i <= 20; i++)
      send("sat", K1, 16'd10, 10 + i, 16'((i > 15) ? 15 : i), 32'(10 * i), 0, 0);

    sel = 2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_sweep("win_init", 1'b0);
    send("win1", K1, 16'd3, 40, 16'd1, 32'd3, 0, 0);
    send("win2", K1, 16'd3, 41, 16'd2, 32'd6, 0, 0);
    while (cyc < 1000) @(negedge clk);
    chk("win.before", 64'(m_clearing), 64'd0);
    @(negedge clk);
    chk("win.start", 64'(m_clearing), 64'd1);
    wait_sweep("win", 1'b0);
    send("win_after", K1, 16'd4, 42, 16'd1, 32'd4, 0, 0);

    // Reset while a packet is in LOOKUP: packet abandoned, sweep restarts.
    sel = 0;
    flow_key = K1; pkt_bytes = 16'd8; vld[0] = 1'b1;
    @(negedge clk);
    vld = '0;
    rst_n = 1'b0;
    #1;
    chk("midrst.clearing", 64'(m_clearing), 64'd1);
    chk("midrst.ready", 64'(m_ready), 64'd0);
    chk("midrst.valid", 64'(m_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sweep("midrst", 1'b0);
    send("midrst_after", K1, 16'd11, 60, 16'd1, 32'd11, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fem_sketch.md
FEM_SKETCH -- requirements
Module: fem_sketch

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each pass-through feature word.
REQ-002 Parameter N_FEATURES, default 28: number of feature words per packet.
REQ-003 Parameter N_HASH, default 4: number of sketch rows, range 1..8.
REQ-004 Parameter SKETCH_DEPTH, default 256: counters per row, power of two, at least 4; IDX_W = log2(SKETCH_DEPTH).
REQ-005 Parameter KEY_WIDTH, default 104: flow-key width (5-tuple).
REQ-006 Parameter CNT_WIDTH, default 16: packet-counter width.
REQ-007 Parameter BYTE_WIDTH, default 32: byte-counter width.
REQ-008 Parameter WINDOW_CYCLES, default 0: measurement window length in clocks; 0 disables automatic clearing.
REQ-009 clk, input, 1: single clock; all logic is on the rising edge.
REQ-010 rst_n, input, 1: asynchronous active-low reset.
REQ-011 pkt_valid / pkt_ready, input / output, 1 each: input handshake; a transfer occurs when both are high.
REQ-012 flow_key, input, KEY_WIDTH: flow identifier.
REQ-013 pkt_bytes, input, 16: packet length in bytes.
REQ-014 pkt_features, input, N_FEATURES x DATA_WIDTH: per-packet features.
REQ-015 clear_req, input, 1: one-cycle pulse requesting a sketch clear.
REQ-016 agg_valid / agg_ready, output / input, 1 each: output handshake.
REQ-017 agg_features, output, N_FEATURES x DATA_WIDTH: registered copy of the accepted packet's features.
REQ-018 agg_pkt_est, output, CNT_WIDTH: count-min packet estimate for the flow.
REQ-019 agg_byte_est, output, BYTE_WIDTH: count-min byte estimate for the flow.
REQ-020 clearing, output, 1: high while a clear sweep is in progress.

Function
REQ-021 FSM states: CLEAR, IDLE, LOOKUP, UPDATE, OUTPUT. pkt_ready is high only in IDLE.
REQ-022 Row-h index: k_h = flow_key XOR rotate-left(flow_key, 7h+1); the index is the XOR of all IDX_W-bit slices of k_h, with the top slice zero-padded.
REQ-023 IDLE with a transfer: latch key, bytes and features, then go to LOOKUP.
REQ-024 LOOKUP, one cycle: read all N_HASH row counters at their indices, then go to UPDATE.
REQ-025 UPDATE, one cycle: each row writes pkt+1 and byte+pkt_bytes back, saturating at all-ones.
REQ-026 In UPDATE, the estimates are the minimum of the post-update values across rows; they are registered, and the FSM goes to OUTPUT.
REQ-027 OUTPUT: agg_valid is high and all agg_* outputs are stable until agg_ready.
REQ-028 On the agg_ready handshake: agg_valid falls on the next edge and the FSM goes to IDLE, or to CLEAR if a clear is pending.
REQ-029 Latency: agg_valid rises 3 cycles after the accepting edge. Throughput is one packet per 4 cycles with agg_ready held high.
REQ-030 CLEAR: sweeps addresses 0..SKETCH_DEPTH-1, one per cycle, zeroing every row at that address. It lasts exactly SKETCH_DEPTH cycles with clearing high, then goes to IDLE.
REQ-031 Window counter: counts every cycle when WINDOW_CYCLES>0. At WINDOW_CYCLES-1 it wraps to 0 and sets a clear-pending flag; a clear_req pulse also sets the flag.
REQ-032 The clear-pending flag is acted on only from IDLE or at the end of OUTPUT. A packet in flight always completes against the uncleared sketch.
REQ-033 A pulse arriving in the same IDLE cycle as pkt_valid: the packet is accepted first, and the clear follows after its OUTPUT.
REQ-034 Requests arriving during CLEAR are ignored, with the flag held cleared. Multiple pending requests collapse to one sweep.
REQ-035 If two rows hash to the same index for one key, the rows are independent; there is no conflict.

Reset
REQ-036 Reset forces pkt_ready=0, agg_valid=0, agg_features=0, agg_pkt_est=0, agg_byte_est=0, clearing=1, window counter=0, clear-pending=0, and FSM=CLEAR at address 0.
REQ-037 After rst_n deasserts, a full SKETCH_DEPTH-cycle sweep runs before the first pkt_ready.
REQ-038 Reset asserted mid-operation abandons any packet or sweep immediately, with no output handshake.

Verification
REQ-039 Post-reset: pkt_ready=0 and clearing=1 for exactly 256 cycles; then pkt_ready=1 and clearing=0.
REQ-040 Estimates: send key K three times with bytes 100, 200, 300 and agg_ready=1 -> pkt_est 1/2/3, byte_est 100/300/600. Each agg_valid appears 3 cycles after acceptance, and features are echoed exactly.
REQ-041 Backpressure: hold agg_ready=0 for 10 cycles -> agg_valid and all outputs remain constant, pkt_ready=0; releasing gives one handshake.
REQ-042 Saturation: CNT_WIDTH=4, send the same key 20 times -> pkt_est goes 1..15 then stays 15.
REQ-043 Clear: pulse clear_req in OUTPUT -> sweep begins after the handshake; resending K afterwards gives pkt_est=1.
REQ-044 Window: WINDOW_CYCLES=1000 -> a sweep starts at the first IDLE at or after cycle 999 of the window, and the counts for K restart at 1.
